// File: rtl/ipv4_csum_ttl_update.sv
// ipv4_csum_ttl_update
//   Header-checksum stage for the router output-port-lookup pipeline.
//   Incoming AXI4-Stream beats are buffered in a small FIFO. When a packet's
//   first beat reaches the FIFO head, the upstream 32-bit partial header sums
//   and the low destination-IP word are sampled, added, and folded to a
//   16-bit one's-complement result over two cycles. The header beat is then
//   presented with TUSER flags (bad checksum / TTL expired) or, for a good
//   live packet, with TTL decremented and the checksum patched incrementally.
//   The remaining beats pass through unchanged.
//
// Ports
//   AXI_ACLK, AXI_RESETN      clock, asynchronous active-low reset
//   S_AXIS_*                  input stream (TREADY = FIFO not nearly full)
//   M_AXIS_*                  output stream (all zero while TVALID is low)
//   partial_sum_in            NUM_PARTIALS x 32-bit upstream partial sums
//   low_ip_addr_in            low 16 bits of destination IP
//   csum_capture              high in the cycle the sums are sampled
//   csum_final, csum_ok       last folded sum, and whether it was 16'hFFFF
//   bad_csum_count            saturating count of checksum failures
//   ttl_exp_count             saturating count of TTL-expired packets
module ipv4_csum_ttl_update #(
   parameter int C_M_AXIS_DATA_WIDTH  = 256,
   parameter int C_S_AXIS_DATA_WIDTH  = 256,
   parameter int C_M_AXIS_TUSER_WIDTH = 128,
   parameter int C_S_AXIS_TUSER_WIDTH = 128,
   parameter int NUM_PARTIALS         = 2,
   parameter int FIFO_DEPTH_BITS      = 2,
   parameter int DECR_TTL             = 1,
   parameter int TTL_POS              = 72,
   parameter int CSUM_POS             = 48,
   parameter int BAD_CSUM_POS         = 32,
   parameter int TTL_EXP_POS          = 33
) (
   input  logic                              AXI_ACLK,
   input  logic                              AXI_RESETN,
   input  logic [C_S_AXIS_DATA_WIDTH-1:0]    S_AXIS_TDATA,
   input  logic [C_S_AXIS_DATA_WIDTH/8-1:0]  S_AXIS_TSTRB,
   input  logic [C_S_AXIS_TUSER_WIDTH-1:0]   S_AXIS_TUSER,
   input  logic                              S_AXIS_TVALID,
   output logic                              S_AXIS_TREADY,
   input  logic                              S_AXIS_TLAST,
   output logic [C_M_AXIS_DATA_WIDTH-1:0]    M_AXIS_TDATA,
   output logic [C_M_AXIS_DATA_WIDTH/8-1:0]  M_AXIS_TSTRB,
   output logic [C_M_AXIS_TUSER_WIDTH-1:0]   M_AXIS_TUSER,
   output logic                              M_AXIS_TVALID,
   input  logic                              M_AXIS_TREADY,
   output logic                              M_AXIS_TLAST,
   input  logic [32*NUM_PARTIALS-1:0]        partial_sum_in,
   input  logic [15:0]                       low_ip_addr_in,
   output logic                              csum_capture,
   output logic [15:0]                       csum_final,
   output logic                              csum_ok,
   output logic [31:0]                       bad_csum_count,
   output logic [31:0]                       ttl_exp_count
);

   localparam int DW    = C_M_AXIS_DATA_WIDTH;
   localparam int UW    = C_M_AXIS_TUSER_WIDTH;
   localparam int KW    = DW / 8;
   localparam int SW    = 32 + $clog2(NUM_PARTIALS + 1);
   localparam int DEPTH = 2 ** FIFO_DEPTH_BITS;

   typedef struct packed {
      logic          last;
      logic [UW-1:0] user;
      logic [KW-1:0] strb;
      logic [DW-1:0] data;
   } beat_t;

   typedef enum logic [2:0] {IDLE, FOLD1, FOLD2, HDR, BODY} state_t;

   // ---------------- input FIFO ----------------
   beat_t                      mem [DEPTH];
   logic [FIFO_DEPTH_BITS-1:0] wr_ptr, rd_ptr;
   logic [FIFO_DEPTH_BITS:0]   count;
   logic                       fifo_empty, nearly_full, fifo_wr, fifo_rd;
   beat_t                      head;

   assign fifo_empty    = (count == '0);
   assign nearly_full   = (count >= (FIFO_DEPTH_BITS+1)'(DEPTH - 1));
   // Gated by reset so the port reads 0 while reset is held.
   assign S_AXIS_TREADY = AXI_RESETN & ~nearly_full;
   assign fifo_wr       = S_AXIS_TVALID & S_AXIS_TREADY;
   assign head          = mem[rd_ptr];

   always_ff @(posedge AXI_ACLK) begin
      if (fifo_wr)
         mem[wr_ptr] <= {S_AXIS_TLAST, UW'(S_AXIS_TUSER), KW'(S_AXIS_TSTRB), DW'(S_AXIS_TDATA)};
   end

   always_ff @(posedge AXI_ACLK or negedge AXI_RESETN) begin
      if (!AXI_RESETN) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (fifo_wr) wr_ptr <= wr_ptr + 1'b1;
         if (fifo_rd) rd_ptr <= rd_ptr + 1'b1;
         if (fifo_wr && !fifo_rd)      count <= count + 1'b1;
         else if (!fifo_wr && fifo_rd) count <= count - 1'b1;
      end
   end

   // ---------------- control FSM ----------------
   state_t state, state_nx;
   logic   m_valid;

   always_ff @(posedge AXI_ACLK or negedge AXI_RESETN) begin
      if (!AXI_RESETN) state <= IDLE;
      else             state <= state_nx;
   end

   always_comb begin
      state_nx     = state;
      m_valid      = 1'b0;
      csum_capture = 1'b0;
      case (state)
         // The FIFO only ever holds whole-packet remainders behind the
         // packet being forwarded, so anything at the head in IDLE is a
         // first beat.
         IDLE: if (!fifo_empty) begin
            csum_capture = 1'b1;
            state_nx     = FOLD1;
         end
         FOLD1: state_nx = FOLD2;
         FOLD2: state_nx = HDR;
         HDR: begin
            m_valid = !fifo_empty;
            if (m_valid && M_AXIS_TREADY)
               state_nx = head.last ? IDLE : BODY;
         end
         BODY: begin
            m_valid = !fifo_empty;
            if (m_valid && M_AXIS_TREADY && head.last)
               state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   assign fifo_rd = m_valid & M_AXIS_TREADY;

   // ---------------- checksum folding ----------------
   logic [SW-1:0]  psum, s_reg;
   logic [SW-16:0] s1_reg;
   logic [16:0]    s2;
   logic [15:0]    fold;

   always_comb begin
      psum = SW'(low_ip_addr_in);
      for (int i = 0; i < NUM_PARTIALS; i++)
         psum = psum + SW'(partial_sum_in[32*i +: 32]);
   end

   // Two folds bound any carry to one bit; the last add of that bit cannot
   // overflow because a set carry implies a small low half.
   assign s2   = 17'(s1_reg[15:0]) + 17'(s1_reg[SW-16:16]);
   assign fold = s2[15:0] + {15'd0, s2[16]};

   // ---------------- header patch ----------------
   logic [7:0]  ttl;
   logic [15:0] hc, hc_new;
   logic [16:0] hc_inc;
   logic        ttl_exp, hdr_hs;
   beat_t       out_beat;

   assign ttl     = head.data[TTL_POS +: 8];
   assign hc      = head.data[CSUM_POS +: 16];
   assign ttl_exp = (ttl <= 8'd1);
   // TTL sits in the high byte of its header word, so TTL-1 lowers the
   // one's-complement sum by 0x0100 and the stored checksum rises by 0x0100.
   assign hc_inc  = {1'b0, hc} + 17'h00100;
   assign hc_new  = hc_inc[15:0] + {15'd0, hc_inc[16]};
   assign hdr_hs  = (state == HDR) && m_valid && M_AXIS_TREADY;

   always_comb begin
      out_beat = head;
      if (state == HDR) begin
         if (!csum_ok)
            out_beat.user[BAD_CSUM_POS] = 1'b1;
         else if (ttl_exp)
            out_beat.user[TTL_EXP_POS] = 1'b1;
         else if (DECR_TTL != 0) begin
            out_beat.data[TTL_POS +: 8]   = ttl - 8'd1;
            out_beat.data[CSUM_POS +: 16] = hc_new;
         end
      end
   end

   // Outputs are forced to zero when not valid so reset shows all-zero ports.
   assign M_AXIS_TVALID = m_valid;
   assign M_AXIS_TDATA  = m_valid ? out_beat.data : '0;
   assign M_AXIS_TSTRB  = m_valid ? out_beat.strb : '0;
   assign M_AXIS_TUSER  = m_valid ? out_beat.user : '0;
   assign M_AXIS_TLAST  = m_valid & out_beat.last;

   // ---------------- result registers and counters ----------------
   always_ff @(posedge AXI_ACLK or negedge AXI_RESETN) begin
      if (!AXI_RESETN) begin
         s_reg          <= '0;
         s1_reg         <= '0;
         csum_final     <= '0;
         csum_ok        <= 1'b0;
         bad_csum_count <= '0;
         ttl_exp_count  <= '0;
      end else begin
         if (csum_capture)
            s_reg <= psum;
         if (state == FOLD1)
            s1_reg <= (SW-15)'(s_reg[15:0]) + (SW-15)'(s_reg[SW-1:16]);
         if (state == FOLD2) begin
            csum_final <= fold;
            csum_ok    <= (fold == 16'hFFFF);
         end
         if (hdr_hs) begin
            if (!csum_ok) begin
               if (bad_csum_count != 32'hFFFF_FFFF) bad_csum_count <= bad_csum_count + 32'd1;
            end else if (ttl_exp) begin
               if (ttl_exp_count != 32'hFFFF_FFFF) ttl_exp_count <= ttl_exp_count + 32'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_ipv4_csum_ttl_update.sv
// tb_ipv4_csum_ttl_update
//   Directed and randomized packets against a packet-level reference model:
//   checksum by repeated end-around folding, header rewrite rules applied to
//   whole packets, expected beats kept in a queue and compared on every
//   output handshake. Also checks hold-under-backpressure, header latency,
//   reset values and mid-packet reset recovery.
module tb_ipv4_csum_ttl_update;

   localparam int DW = 256;
   localparam int UW = 128;
   localparam int KW = DW / 8;

   typedef struct packed {
      logic [DW-1:0] d;
      logic [UW-1:0] u;
      logic [KW-1:0] s;
      logic          l;
   } beat_t;

   logic          clk = 1'b0;
   logic          AXI_RESETN;
   logic [DW-1:0] S_AXIS_TDATA;
   logic [KW-1:0] S_AXIS_TSTRB;
   logic [UW-1:0] S_AXIS_TUSER;
   logic          S_AXIS_TVALID, S_AXIS_TREADY, S_AXIS_TLAST;
   logic [DW-1:0] M_AXIS_TDATA;
   logic [KW-1:0] M_AXIS_TSTRB;
   logic [UW-1:0] M_AXIS_TUSER;
   logic          M_AXIS_TVALID, M_AXIS_TLAST;
   logic          M_AXIS_TREADY = 1'b0;
   logic [63:0]   partial_sum_in;
   logic [15:0]   low_ip_addr_in;
   logic          csum_capture, csum_ok;
   logic [15:0]   csum_final;
   logic [31:0]   bad_csum_count, ttl_exp_count;

   always #5 clk = ~clk;

   ipv4_csum_ttl_update dut (
      .AXI_ACLK(clk), .AXI_RESETN(AXI_RESETN),
      .S_AXIS_TDATA(S_AXIS_TDATA), .S_AXIS_TSTRB(S_AXIS_TSTRB), .S_AXIS_TUSER(S_AXIS_TUSER),
      .S_AXIS_TVALID(S_AXIS_TVALID), .S_AXIS_TREADY(S_AXIS_TREADY), .S_AXIS_TLAST(S_AXIS_TLAST),
      .M_AXIS_TDATA(M_AXIS_TDATA), .M_AXIS_TSTRB(M_AXIS_TSTRB), .M_AXIS_TUSER(M_AXIS_TUSER),
      .M_AXIS_TVALID(M_AXIS_TVALID), .M_AXIS_TREADY(M_AXIS_TREADY), .M_AXIS_TLAST(M_AXIS_TLAST),
      .partial_sum_in(partial_sum_in), .low_ip_addr_in(low_ip_addr_in),
      .csum_capture(csum_capture), .csum_final(csum_final), .csum_ok(csum_ok),
      .bad_csum_count(bad_csum_count), .ttl_exp_count(ttl_exp_count)
   );

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // ---------------- model state ----------------
   beat_t       exp_q [$];
   logic [15:0] hq [$];
   int          mdl_bad = 0, mdl_exp = 0;

   // ---------------- ready generator ----------------
   int   rdy_mode = 0;   // 0 hold, 1 toggle, 2 random
   logic rdy_hold = 1'b1;
   always @(posedge clk) begin
      #1;
      case (rdy_mode)
         1:       M_AXIS_TREADY = ~M_AXIS_TREADY;
         2:       M_AXIS_TREADY = (($urandom % 4) != 0);
         default: M_AXIS_TREADY = rdy_hold;
      endcase
   end

   // ---------------- monitor ----------------
   int            cyc = 0;
   int            cap_cnt = 0, cap_cyc = 0;
   logic          mon_en = 1'b1, saw_drop = 1'b0;
   logic          stall = 1'b0, in_body = 1'b0, lat_pending = 1'b0;
   beat_t         held;
   logic [DW-1:0] last_hdr_d;
   logic [UW-1:0] last_hdr_u;

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      if (!AXI_RESETN) begin
         stall = 1'b0; in_body = 1'b0; lat_pending = 1'b0;
      end else begin
         if (csum_capture) begin
            cap_cnt++;
            if (mon_en) begin lat_pending = 1'b1; cap_cyc = cyc; end
         end
         if (!S_AXIS_TREADY) saw_drop = 1'b1;
         if (mon_en) begin
            if (stall) begin
               chk("hold_valid", 256'(M_AXIS_TVALID), 256'(1));
               chk("hold_data",  256'(M_AXIS_TDATA), 256'(held.d));
               chk("hold_user",  256'(M_AXIS_TUSER), 256'(held.u));
               chk("hold_last",  256'(M_AXIS_TLAST), 256'(held.l));
            end
            if (M_AXIS_TVALID && lat_pending) begin
               chk("hdr_latency", 256'(cyc - cap_cyc), 256'(3));
               lat_pending = 1'b0;
            end
            if (M_AXIS_TVALID && M_AXIS_TREADY) begin
               chk("beat_expected", 256'(exp_q.size() > 0), 256'(1));
               if (exp_q.size() > 0) begin
                  beat_t e;
                  e = exp_q.pop_front();
                  chk("tdata", 256'(M_AXIS_TDATA), 256'(e.d));
                  chk("tuser", 256'(M_AXIS_TUSER), 256'(e.u));
                  chk("tstrb", 256'(M_AXIS_TSTRB), 256'(e.s));
                  chk("tlast", 256'(M_AXIS_TLAST), 256'(e.l));
               end
               if (!in_body) begin
                  last_hdr_d = M_AXIS_TDATA;
                  last_hdr_u = M_AXIS_TUSER;
                  if (hq.size() > 0) begin
                     logic [15:0] f;
                     f = hq.pop_front();
                     chk("csum_final", 256'(csum_final), 256'(f));
                     chk("csum_ok", 256'(csum_ok), 256'(f == 16'hFFFF));
                  end
               end
               in_body = !M_AXIS_TLAST;
            end
            stall = M_AXIS_TVALID && !M_AXIS_TREADY;
            held  = '{M_AXIS_TDATA, M_AXIS_TUSER, M_AXIS_TSTRB, M_AXIS_TLAST};
         end
      end
   end

   // ---------------- helpers ----------------
   function automatic logic [DW-1:0] rnd_data();
      logic [DW-1:0] r;
      for (int i = 0; i < DW/32; i++) r[32*i +: 32] = $urandom;
      return r;
   endfunction

   function automatic logic [15:0] ones_fold(input logic [63:0] x);
      logic [63:0] v;
      v = x;
      while (v > 64'hFFFF) v = (v & 64'hFFFF) + (v >> 16);
      return v[15:0];
   endfunction

   // Called aligned to posedge+1.
   task automatic push_beat(input beat_t b);
      logic ok;
      int   n;
      S_AXIS_TDATA = b.d; S_AXIS_TUSER = b.u; S_AXIS_TSTRB = b.s; S_AXIS_TLAST = b.l;
      S_AXIS_TVALID = 1'b1;
      n = 0;
      do begin
         @(negedge clk); ok = S_AXIS_TREADY;
         @(posedge clk); #1;
         n++;
      end while (!ok && n < 1000);
      if (!ok) chk("s_ready_timeout", 256'(ok), 256'(1));
   endtask

   task automatic build_pkt(input int nb, input logic [7:0] ttl, input logic [15:0] hc,
                            output beat_t b [$]);
      b.delete();
      for (int i = 0; i < nb; i++) begin
         beat_t x;
         x.d = rnd_data();
         x.u = {$urandom, $urandom, $urandom, $urandom};
         x.u[33:32] = 2'b00;
         x.s = $urandom;
         x.l = (i == nb - 1);
         if (i == 0) begin x.d[79:72] = ttl; x.d[63:48] = hc; end
         b.push_back(x);
      end
   endtask

   // Queue the expected output of a packet and send it.
   task automatic send_pkt(input logic [31:0] p0, input logic [31:0] p1, input logic [15:0] low,
                           input int nb, input logic [7:0] ttl, input logic [15:0] hc);
      beat_t       b [$];
      beat_t       e;
      logic [15:0] f;
      int          start, n, hcn;
      build_pkt(nb, ttl, hc, b);
      f = ones_fold(64'(p0) + 64'(p1) + 64'(low));
      e = b[0];
      if (f != 16'hFFFF) begin
         e.u[32] = 1'b1; mdl_bad++;
      end else if (ttl <= 8'd1) begin
         e.u[33] = 1'b1; mdl_exp++;
      end else begin
         e.d[79:72] = ttl - 8'd1;
         hcn = int'(hc) + 'h100;
         if (hcn > 'hFFFF) hcn = hcn - 'hFFFF;
         e.d[63:48] = 16'(hcn);
      end
      exp_q.push_back(e);
      for (int i = 1; i < nb; i++) exp_q.push_back(b[i]);
      hq.push_back(f);
      partial_sum_in = {p1, p0};
      low_ip_addr_in = low;
      start = cap_cnt;
      foreach (b[i]) push_beat(b[i]);
      S_AXIS_TVALID = 1'b0;
      n = 0;
      while (cap_cnt == start && n < 500) begin @(posedge clk); #1; n++; end
      chk("capture_seen", 256'(cap_cnt > start), 256'(1));
   endtask

   task automatic drain(input string tag);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 3000) begin @(posedge clk); #1; n++; end
      repeat (3) @(posedge clk);
      #1;
      chk({tag, "_drained"}, 256'(exp_q.size()), 256'(0));
      chk({tag, "_bad_cnt"}, 256'(bad_csum_count), 256'(mdl_bad));
      chk({tag, "_exp_cnt"}, 256'(ttl_exp_count), 256'(mdl_exp));
   endtask

   // ---------------- main sequence ----------------
   initial begin
      beat_t ra [$];
      int    n;
      AXI_RESETN = 1'b0;
      S_AXIS_TVALID = 1'b0; S_AXIS_TDATA = '0; S_AXIS_TUSER = '0; S_AXIS_TSTRB = '0; S_AXIS_TLAST = 1'b0;
      partial_sum_in = '0; low_ip_addr_in = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_tvalid", 256'(M_AXIS_TVALID), 256'(0));
      chk("rst_tready", 256'(S_AXIS_TREADY), 256'(0));
      chk("rst_capture", 256'(csum_capture), 256'(0));
      chk("rst_csum", 256'(csum_final), 256'(0));
      chk("rst_ok", 256'(csum_ok), 256'(0));
      chk("rst_bad_cnt", 256'(bad_csum_count), 256'(0));
      chk("rst_exp_cnt", 256'(ttl_exp_count), 256'(0));
      @(negedge clk) AXI_RESETN = 1'b1;
      @(posedge clk); #1;

      // Good header
      send_pkt(32'h0000C584, 32'h000239B2, 16'h00C7, 2, 8'h40, 16'hB861);
      drain("good");
      chk("good_csum", 256'(csum_final), 256'(16'hFFFF));
      chk("good_ok", 256'(csum_ok), 256'(1));
      chk("good_ttl", 256'(last_hdr_d[79:72]), 256'(8'h3F));
      chk("good_hc", 256'(last_hdr_d[63:48]), 256'(16'hB961));
      chk("good_flags", 256'(last_hdr_u[33:32]), 256'(0));

      // Corrupt sum
      send_pkt(32'h0000C584, 32'h000239B3, 16'h00C7, 1, 8'h40, 16'hB861);
      drain("corrupt");
      chk("corrupt_csum", 256'(csum_final), 256'(16'h0001));
      chk("corrupt_ok", 256'(csum_ok), 256'(0));
      chk("corrupt_flag", 256'(last_hdr_u[32]), 256'(1));
      chk("corrupt_ttl", 256'(last_hdr_d[79:72]), 256'(8'h40));
      chk("corrupt_hc", 256'(last_hdr_d[63:48]), 256'(16'hB861));
      chk("corrupt_cnt", 256'(bad_csum_count), 256'(1));

      // TTL expiry
      send_pkt(32'h0000C584, 32'h000239B2, 16'h00C7, 2, 8'h01, 16'hB861);
      drain("ttlexp");
      chk("ttlexp_flag", 256'(last_hdr_u[33]), 256'(1));
      chk("ttlexp_ttl", 256'(last_hdr_d[79:72]), 256'(8'h01));
      chk("ttlexp_hc", 256'(last_hdr_d[63:48]), 256'(16'hB861));
      chk("ttlexp_cnt", 256'(ttl_exp_count), 256'(1));

      // Carry wrap
      send_pkt(32'h0000C584, 32'h000239B2, 16'h00C7, 1, 8'h05, 16'hFF00);
      drain("wrap");
      chk("wrap_hc", 256'(last_hdr_d[63:48]), 256'(16'h0001));
      chk("wrap_ttl", 256'(last_hdr_d[79:72]), 256'(8'h04));

      // Backpressure, toggling ready
      saw_drop = 1'b0;
      rdy_mode = 1;
      send_pkt(32'h0000C584, 32'h000239B2, 16'h00C7, 3, 8'h20, 16'h1234);
      send_pkt(32'h0000C584, 32'h000239B2, 16'h00C7, 3, 8'h21, 16'h4321);
      drain("bp");
      rdy_mode = 0; rdy_hold = 1'b1;
      chk("bp_tready_drop", 256'(saw_drop), 256'(1));

      // Reset during BODY of packet A
      mon_en = 1'b0; rdy_hold = 1'b0;
      @(posedge clk); #1;
      build_pkt(5, 8'h30, 16'h5555, ra);
      partial_sum_in = {32'h000239B2, 32'h0000C584}; low_ip_addr_in = 16'h00C7;
      for (int i = 0; i < 3; i++) push_beat(ra[i]);
      S_AXIS_TVALID = 1'b0;
      n = 0;
      do begin @(negedge clk); n++; end while (!M_AXIS_TVALID && n < 100);
      rdy_hold = 1'b1;
      @(negedge clk);
      rdy_hold = 1'b0;
      @(negedge clk);
      chk("body_valid", 256'(M_AXIS_TVALID), 256'(1));
      AXI_RESETN = 1'b0;
      #1;
      chk("midrst_tvalid", 256'(M_AXIS_TVALID), 256'(0));
      chk("midrst_tdata", 256'(M_AXIS_TDATA), 256'(0));
      chk("midrst_tuser", 256'(M_AXIS_TUSER), 256'(0));
      chk("midrst_csum", 256'(csum_final), 256'(0));
      chk("midrst_bad_cnt", 256'(bad_csum_count), 256'(0));
      chk("midrst_exp_cnt", 256'(ttl_exp_count), 256'(0));
      exp_q.delete(); hq.delete();
      mdl_bad = 0; mdl_exp = 0;
      repeat (2) @(negedge clk);
      AXI_RESETN = 1'b1;
      mon_en = 1'b1; rdy_hold = 1'b1;
      @(posedge clk); #1;
      send_pkt(32'h0000C584, 32'h000239B2, 16'h00C7, 3, 8'h40, 16'hB861);
      drain("after_rst");
      chk("after_rst_hc", 256'(last_hdr_d[63:48]), 256'(16'hB961));
      chk("after_rst_ok", 256'(csum_ok), 256'(1));

      // Randomized packets with random ready
      rdy_mode = 2;
      for (int k = 0; k < 40; k++) begin
         logic [31:0] p0, p1;
         logic [15:0] low, fx;
         logic [7:0]  ttl;
         p0  = $urandom;
         low = 16'($urandom);
         fx  = ones_fold(64'(p0) + 64'(low));
         if (($urandom % 4) == 0) p1 = $urandom;
         else p1 = 32'(16'hFFFF - fx) + ($urandom % 256) * 32'h0000FFFF;
         case ($urandom % 4)
            0:       ttl = 8'h00;
            1:       ttl = 8'h01;
            2:       ttl = 8'h02;
            default: ttl = 8'($urandom);
         endcase
         send_pkt(p0, p1, low, 1 + int'($urandom % 4), ttl, 16'($urandom));
      end
      drain("random");
      rdy_mode = 0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #800000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/ipv4_csum_ttl_update.md
Name: ipv4_csum_ttl_update

Overview:
- Next-generation header-checksum stage in the router output-port-lookup pipeline.
- Buffers the AXI4-Stream packet and captures N upstream 32-bit partial header sums plus the low IP-address word.
- Folds the sums to a 16-bit one's-complement result and verifies the IPv4 header checksum.
- Optionally decrements TTL with an incremental checksum patch (RFC 1624) in the first beat; flags bad or expired packets in TUSER and counts them.

Parameters:
C_M_AXIS_DATA_WIDTH, 256, master TDATA width
C_S_AXIS_DATA_WIDTH, 256, slave TDATA width (must equal master)
C_M_AXIS_TUSER_WIDTH, 128, master TUSER width
C_S_AXIS_TUSER_WIDTH, 128, slave TUSER width
NUM_PARTIALS, 2, number of 32-bit partial sums (1..8)
FIFO_DEPTH_BITS, 2, input FIFO depth = 2**FIFO_DEPTH_BITS beats
DECR_TTL, 1, 1 = decrement TTL and patch checksum; 0 = verify only
TTL_POS, 72, LSB of TTL byte in first beat
CSUM_POS, 48, LSB of header-checksum field in first beat
BAD_CSUM_POS, 32, TUSER bit set on checksum failure
TTL_EXP_POS, 33, TUSER bit set when TTL <= 1

Ports:
AXI_ACLK  in  1  clock
AXI_RESETN  in  1  asynchronous active-low reset
S_AXIS_TDATA/TSTRB/TUSER/TVALID/TREADY/TLAST  in/in/in/in/out/in  DATA/DATA/8/TUSER/1/1/1  input stream
M_AXIS_TDATA/TSTRB/TUSER/TVALID/TREADY/TLAST  out/out/out/out/in/out  same widths  output stream
partial_sum_in  in  32*NUM_PARTIALS  upstream partial header sums, stable until csum_capture
low_ip_addr_in  in  16  low 16 bits of destination IP
csum_capture  out  1  one-cycle pulse when partials are sampled
csum_final  out  16  last folded sum
csum_ok  out  1  last header verified (csum_final == 16'hFFFF)
bad_csum_count  out  32  saturating count of checksum failures
ttl_exp_count  out  32  saturating count of TTL-expired packets

Behaviour:
- Reset (async, AXI_RESETN low):
  - FIFO emptied; state IDLE.
  - All outputs 0, including M_AXIS_TVALID, csum_capture, csum_final, csum_ok, counters.
- S_AXIS_TREADY = !fifo_nearly_full; FIFO write on S_AXIS_TVALID & S_AXIS_TREADY.
- States: IDLE, FOLD1, FOLD2, HDR, BODY.
- IDLE:
  - When FIFO non-empty, head is a first beat: register s = sum(partials) + low_ip_addr_in.
  - s width is 32 + clog2(NUM_PARTIALS+1); pulse csum_capture; go to FOLD1.
- FOLD1: s1 = s[15:0] + s[hi:16]; go to FOLD2.
- FOLD2:
  - s2 = s1[15:0] + s1[hi:16]; f = s2[15:0] + s2[16].
  - Register csum_final = f, csum_ok = (f == 16'hFFFF); go to HDR.
- HDR:
  - M_AXIS_TVALID = 1 with the first beat; M_AXIS_TVALID is 0 in IDLE/FOLD1/FOLD2.
  - Header is latched on M 3 cycles after reaching FIFO head.
  - bad = !csum_ok; exp = (TTL byte <= 1).
  - If bad: set TUSER[BAD_CSUM_POS]; data unmodified.
  - Else if exp: set TUSER[TTL_EXP_POS]; data unmodified.
  - Else if DECR_TTL: TTL -= 1; checksum field = HC + 16'h0100 with end-around carry (0xFF00 -> 0x0001).
  - Counters increment once per packet on the HDR handshake; both saturate at 32'hFFFFFFFF.
  - On M_AXIS_TVALID & M_AXIS_TREADY: if TLAST go to IDLE, else go to BODY.
- BODY:
  - Pass-through: M_AXIS_TVALID = !fifo_empty; FIFO read on M_AXIS_TVALID & M_AXIS_TREADY.
  - On the TLAST handshake go to IDLE.
- Backpressure: TDATA, TUSER, TSTRB, TLAST and the patched header are held stable while TVALID & !TREADY.
- Single-beat packet: processed as a header; HDR returns directly to IDLE.
- Reset mid-packet: the partial packet is discarded; the first beat after reset is treated as a header.
- Reset while FOLD1/FOLD2: no output emitted.

Test Plan:
- Good header, TTL 0x40, HC 0xB861:
  - Stimulus: partials 0x0000C584, 0x000239B2; low_ip 0x00C7; DECR_TTL=1.
  - Required: csum_final = 0xFFFF, csum_ok = 1; output TTL 0x3F, HC 0xB961; TUSER flag bits 0; header valid 3 cycles after head.
- Corrupt sum:
  - Stimulus: partial1 = 0x000239B3.
  - Required: csum_final = 0x0001, csum_ok = 0; TUSER[32] = 1; data unchanged; bad_csum_count = 1.
- TTL expiry:
  - Stimulus: good sum, TTL 0x01.
  - Required: TUSER[33] = 1; TTL and HC unchanged; ttl_exp_count = 1.
- Carry wrap:
  - Stimulus: good sum, HC 0xFF00, TTL 0x05.
  - Required: output HC 0x0001, TTL 0x04.
- Backpressure on a 3-beat packet:
  - Stimulus: M_AXIS_TREADY toggled 1010...; S_AXIS_TVALID held high.
  - Required: beat order and data intact; S_AXIS_TREADY drops when the FIFO reaches nearly-full; no beat lost or duplicated.
- Reset mid-packet:
  - Stimulus: assert AXI_RESETN low during BODY of packet A.
  - Required: all outputs 0 immediately; next packet B is fully processed with correct checksum.
